// File: rtl/rect_pkg.sv
// Rectangle geometry shared by draw_rect and draw_rect_ctl.
package rect_pkg;
   localparam int unsigned RECT_W = 64;
   localparam int unsigned RECT_H = 48;
endpackage

// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 800x600 display pipeline.
package vga_pkg;
   localparam int unsigned H_ACTIVE = 800;
   localparam int unsigned V_ACTIVE = 600;
endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector; RST_VAL seeds the history bit so a level
// already high at reset release is not reported as an edge.
module edge_rise #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);
   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= RST_VAL;
      else     prev <= d;
   end

   assign rise = d & ~prev;
endmodule

// File: rtl/draw_rect_ctl.sv
// Rectangle position controller: follows the mouse, drops on left click,
// falls under per-frame gravity with damped bounces, then rests.
module draw_rect_ctl #(
   parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
   parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
   parameter int unsigned RECT_W     = rect_pkg::RECT_W,
   parameter int unsigned RECT_H     = rect_pkg::RECT_H,
   parameter int unsigned GRAVITY    = 1,
   parameter int unsigned VMAX       = 32,
   parameter int unsigned BOUNCE_MIN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        mouse_left,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        falling
);
   typedef enum logic [1:0] {FOLLOW, FALL, REST} state_t;

   localparam logic        [11:0] XLIM    = 12'(H_ACTIVE - RECT_W);
   localparam logic        [11:0] FLOOR_U = 12'(V_ACTIVE - RECT_H);
   localparam logic signed [12:0] FLOOR   = 13'(V_ACTIVE - RECT_H);
   localparam logic signed [12:0] GRAV_S  = 13'(GRAVITY);
   localparam logic signed [12:0] VMAX_S  = 13'(VMAX);
   localparam logic signed [12:0] BMIN_S  = 13'(BOUNCE_MIN);

   state_t                state;
   logic signed [12:0]    vel;
   logic signed [12:0]    v_inc, v1, y1, rebound;
   logic        [11:0]    x_clamp, y_clamp;
   logic                  tick, click;

   edge_rise #(.RST_VAL(1'b1)) u_vsync_edge (
      .clk (clk), .rst (rst), .d (vsync), .rise (tick)
   );

   edge_rise #(.RST_VAL(1'b1)) u_click_edge (
      .clk (clk), .rst (rst), .d (mouse_left), .rise (click)
   );

   always_comb begin
      v_inc   = vel + GRAV_S;
      v1      = (v_inc > VMAX_S) ? VMAX_S : v_inc;
      y1      = $signed({1'b0, ypos}) + v1;
      // 75% rebound: subtracting the truncated quarter rounds the magnitude up
      rebound = -(v1 - (v1 >>> 2));
      x_clamp = (mouse_xpos > XLIM)    ? XLIM    : mouse_xpos;
      y_clamp = (mouse_ypos > FLOOR_U) ? FLOOR_U : mouse_ypos;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= FOLLOW;
         xpos    <= '0;
         ypos    <= '0;
         vel     <= '0;
         falling <= 1'b0;
      end else begin
         case (state)
            FOLLOW: begin
               if (tick) begin
                  xpos <= x_clamp;
                  ypos <= y_clamp;
               end
               if (click) begin
                  state   <= FALL;
                  vel     <= '0;
                  falling <= 1'b1;
               end
            end
            FALL: begin
               if (tick) begin
                  if (y1 >= FLOOR) begin
                     ypos <= FLOOR_U;
                     if (v1 < BMIN_S) begin
                        vel     <= '0;
                        state   <= REST;
                        falling <= 1'b0;
                     end else begin
                        vel <= rebound;
                     end
                  end else if (y1 < 13'sd0) begin
                     ypos <= '0;
                     vel  <= '0;
                  end else begin
                     ypos <= y1[11:0];
                     vel  <= v1;
                  end
               end
            end
            REST: begin
               if (click) state <= FOLLOW;
            end
            default: begin
               state   <= FOLLOW;
               falling <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_draw_rect_ctl.sv
// Self-checking bench for draw_rect_ctl: directed scenarios plus random
// vsync/click/mouse traffic checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_draw_rect_ctl;
   localparam int FLOOR = 552;
   localparam int XLIM  = 736;

   logic        clk = 1'b0;
   logic        rst;
   logic        vsync;
   logic        mouse_left;
   logic [11:0] mouse_xpos;
   logic [11:0] mouse_ypos;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic        falling;

   int errors = 0;
   int checks = 0;

   // reference model: mode 0=follow, 1=falling, 2=resting
   int m_x, m_y, m_vel, m_mode;
   bit m_vs_prev, m_btn_prev;
   bit btn;

   draw_rect_ctl dut (
      .clk        (clk),
      .rst        (rst),
      .vsync      (vsync),
      .mouse_left (mouse_left),
      .mouse_xpos (mouse_xpos),
      .mouse_ypos (mouse_ypos),
      .xpos       (xpos),
      .ypos       (ypos),
      .falling    (falling)
   );

   always #12 clk = ~clk;

   task automatic check_eq(input string tag, input integer obs, input integer exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      m_x = 0; m_y = 0; m_vel = 0; m_mode = 0;
      m_vs_prev = 1'b1; m_btn_prev = 1'b1;
   endtask

   // One clock edge of the intended behaviour, in plain integer arithmetic.
   task automatic model_step();
      bit tick, click;
      int v, y;
      tick  = vsync && !m_vs_prev;
      click = mouse_left && !m_btn_prev;
      m_vs_prev  = vsync;
      m_btn_prev = mouse_left;
      if (m_mode == 0) begin
         if (tick) begin
            m_x = imin(int'(mouse_xpos), XLIM);
            m_y = imin(int'(mouse_ypos), FLOOR);
         end
         if (click) begin
            m_mode = 1;
            m_vel  = 0;
         end
      end else if (m_mode == 1) begin
         if (tick) begin
            v = imin(m_vel + 1, 32);
            y = m_y + v;
            if (y >= FLOOR) begin
               m_y = FLOOR;
               if (v < 4) begin
                  m_vel  = 0;
                  m_mode = 2;
               end else begin
                  m_vel = -((3 * v + 3) / 4);
               end
            end else if (y < 0) begin
               m_y   = 0;
               m_vel = 0;
            end else begin
               m_y   = y;
               m_vel = v;
            end
         end
      end else begin
         if (click) m_mode = 0;
      end
   endtask

   task automatic check_outputs();
      check_eq("xpos", xpos, m_x);
      check_eq("ypos", ypos, m_y);
      check_eq("falling", falling, (m_mode == 1) ? 1 : 0);
   endtask

   task automatic cyc(input logic vs, input logic ml);
      @(negedge clk);
      vsync      = vs;
      mouse_left = ml;
      @(posedge clk);
      if (!rst) model_step();
      #1;
      check_outputs();
   endtask

   task automatic frame();
      cyc(1'b0, btn);
      cyc(1'b1, btn);
   endtask

   task automatic click_no_tick();
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      btn = 1'b1;
   endtask

   initial begin
      rst = 1'b1; vsync = 1'b1; mouse_left = 1'b1; btn = 1'b1;
      mouse_xpos = '0; mouse_ypos = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_x", xpos, 0);
      check_eq("rst_y", ypos, 0);
      check_eq("rst_falling", falling, 0);

      // vsync and button already high at release: no tick, no click
      mouse_xpos = 12'd400; mouse_ypos = 12'd300;
      @(negedge clk) rst = 1'b0;
      repeat (3) cyc(1'b1, 1'b1);
      check_eq("no_tick_x", xpos, 0);
      check_eq("no_tick_fall", falling, 0);

      mouse_xpos = 12'd900; mouse_ypos = 12'd700;
      frame();
      check_eq("clamp_x", xpos, XLIM);
      check_eq("clamp_y", ypos, FLOOR);
      mouse_xpos = 12'd100; mouse_ypos = 12'd200;
      frame();
      check_eq("track_x", xpos, 100);
      check_eq("track_y", ypos, 200);

      // drop from the top edge
      mouse_xpos = 12'd100; mouse_ypos = 12'd0;
      frame();
      click_no_tick();
      check_eq("drop_falling", falling, 1);
      mouse_xpos = 12'd500; mouse_ypos = 12'd10;
      for (int i = 0; i < 32; i++) begin
         if (i >= 10 && i < 20) begin
            cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b1);
         end else begin
            frame();
         end
      end
      check_eq("fall32_y", ypos, 528);
      check_eq("fall32_x", xpos, 100);
      frame();
      check_eq("impact_y", ypos, FLOOR);
      check_eq("impact_falling", falling, 1);

      for (int i = 0; i < 300 && falling; i++) frame();
      check_eq("rest_reached", falling, 0);
      check_eq("rest_y", ypos, FLOOR);
      repeat (3) frame();
      check_eq("hold_x", xpos, 100);
      check_eq("hold_y", ypos, FLOOR);

      mouse_xpos = 12'd300; mouse_ypos = 12'd123;
      click_no_tick();
      check_eq("rest_click_hold_y", ypos, FLOOR);
      frame();
      check_eq("refollow_x", xpos, 300);
      check_eq("refollow_y", ypos, 123);

      // click and tick on the same edge
      mouse_xpos = 12'd50; mouse_ypos = 12'd60;
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b1);
      btn = 1'b1;
      check_eq("same_edge_x", xpos, 50);
      check_eq("same_edge_y", ypos, 60);
      check_eq("same_edge_falling", falling, 1);

      for (int i = 0; i < 100 && ypos < 300; i++) frame();
      check_eq("midfall_falling", falling, 1);
      #2 rst = 1'b1;
      vsync = 1'b1; mouse_left = 1'b1;
      #1;
      model_reset();
      check_eq("async_rst_x", xpos, 0);
      check_eq("async_rst_y", ypos, 0);
      check_eq("async_rst_falling", falling, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      mouse_xpos = 12'd222; mouse_ypos = 12'd333;
      frame();
      check_eq("post_rst_x", xpos, 222);
      check_eq("post_rst_y", ypos, 333);
      check_eq("post_rst_falling", falling, 0);

      // random traffic
      for (int i = 0; i < 8000; i++) begin
         if ($urandom_range(0, 39) == 0) btn = ~btn;
         if ($urandom_range(0, 15) == 0) begin
            mouse_xpos = 12'($urandom_range(0, 1023));
            mouse_ypos = 12'($urandom_range(0, 1023));
         end
         cyc(1'($urandom_range(0, 1)), btn);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/draw_rect_ctl.md
Name: draw_rect_ctl

Overview:
Position controller for the rectangle drawing stage. It produces the xpos/ypos that the rectangle drawer consumes. In FOLLOW it tracks the mouse. A left click drops the rectangle, which falls under per-frame gravity, bounces with damping off the screen bottom, and comes to rest. Sits between mouse_control and draw_rect in the 40 MHz (clk) domain; all position updates happen once per frame so the rectangle never tears mid-frame.

Parameters:
H_ACTIVE, 800, visible pixels per line
V_ACTIVE, 600, visible lines per frame
RECT_W, 64, rectangle width in pixels
RECT_H, 48, rectangle height in pixels
GRAVITY, 1, velocity increment per frame (px/frame)
VMAX, 32, downward velocity saturation (px/frame)
BOUNCE_MIN, 4, impact speed below which the rectangle rests

Ports:
clk  in  1  pixel clock (40 MHz); sole clock
rst  in  1  asynchronous, active-high reset
vsync  in  1  vsync from vga_timing; its rising edge is the frame tick
mouse_left  in  1  left button level, already in clk domain
mouse_xpos  in  12  mouse x from mouse_control
mouse_ypos  in  12  mouse y from mouse_control
xpos  out  12  rectangle left x, registered
ypos  out  12  rectangle top y, registered
falling  out  1  high in FALL state, registered

Behaviour:
- Reset values:
  - xpos=0, ypos=0, falling=0, state=FOLLOW, vel=0.
  - vsync_prev=1 and btn_prev=1, so no spurious tick or click is seen right after reset.
- Derived limits:
  - FLOOR = V_ACTIVE-RECT_H (552).
  - XLIM = H_ACTIVE-RECT_W (736).
- Tick and click:
  - tick = vsync & ~vsync_prev.
  - click = mouse_left & ~btn_prev.
  - Both prev registers update every cycle.
  - Outputs change on the same edge at which tick is sampled high, i.e. 1-cycle latency from vsync rising.
- vel is signed 13-bit. Positive means downward.
- FOLLOW:
  - On tick: xpos=min(mouse_xpos,XLIM), ypos=min(mouse_ypos,FLOOR).
  - On click: go to FALL, vel=0, falling=1. The position is frozen at its current value.
  - Click and tick in the same cycle: the tick position update is applied and the state still changes to FALL. The first fall step happens on the next tick.
- FALL, on each tick:
  - v1 = min(vel+GRAVITY, VMAX); y1 = ypos+v1 (signed).
  - If y1 >= FLOOR (impact):
    - ypos=FLOOR.
    - If v1 < BOUNCE_MIN: vel=0, go to REST, falling=0.
    - Else: vel = -(v1 - (v1>>2)), i.e. 75% rebound, rounded toward larger magnitude.
  - Else if y1 < 0 (ceiling): ypos=0, vel=0.
  - Else: ypos=y1, vel=v1.
  - xpos is held.
  - Clicks are ignored.
- REST:
  - Position is held.
  - On click: go to FOLLOW. The position follows the mouse from the next tick.
- No tick means no position change in any state. A missing vsync stalls the block, which is legal.
- rst asserted mid-fall returns immediately (asynchronously) to reset values.
- Widths:
  - Sums are done in 13-bit signed. Outputs are clamped to [0,FLOOR] and [0,XLIM], so they never wrap.

Decomposition:
- vga_pkg holds H_ACTIVE/V_ACTIVE defaults.
- A shared rect_pkg holds RECT_W/RECT_H, so draw_rect and draw_rect_ctl agree on the rectangle size.
- The state enum typedef (FOLLOW, FALL, REST) is local to the module.
- One sub-module, edge_rise: a registered rising-edge detector with a reset-value parameter. It is instantiated twice, for vsync and mouse_left.

Test Plan:
- Reset with vsync=1 held → no tick. xpos=ypos=0, falling=0 until vsync drops and rises again.
- FOLLOW with mouse=(900,700), then one vsync rise → xpos=736, ypos=552 one clk later. mouse=(100,200) → (100,200) on the next tick.
- Position (100,0), click, then 32 ticks → vel=32, ypos=528. Tick 33 → impact: ypos=552, vel=-24, falling=1.
- Continue ticking → rebounds of decreasing height. On the first impact with speed <4: ypos=552, falling=0, state REST. Further ticks hold (100,552).
- Clicks during FALL are ignored. A click in REST followed by a tick → position equals the mouse. Click and tick in the same cycle in FOLLOW → position updates and falling=1 on that edge.
- Assert rst mid-fall (ypos≈300) → outputs are 0 asynchronously and the state is FOLLOW. After release, the first tick tracks the mouse.
